// File: rtl/count_pulse_shaper_pkg.sv
// Shared types and constants for the dual-channel count pulse shaper.
// Each channel runs a four-state debounce machine behind a two-flop synchroniser.
package count_pulse_shaper_pkg;

   typedef enum logic [1:0] {
      IDLE_LOW  = 2'd0,
      WAIT_HIGH = 2'd1,
      IDLE_HIGH = 2'd2,
      WAIT_LOW  = 2'd3
   } debounce_state_t;

   localparam int SYNC_STAGES = 2;

endpackage : count_pulse_shaper_pkg

// File: rtl/count_pulse_shaper_debounce_channel.sv
// One conditioning channel: polarity correction, synchroniser, debounce FSM,
// and a registered single-cycle pulse on every accepted rising level.
module debounce_channel
   import count_pulse_shaper_pkg::*;
#(
   parameter int STABLE_CYCLES = 500000,
   parameter bit ACTIVE_LOW    = 1'b1
) (
   input  logic CLK,
   input  logic CLR,
   input  logic EN,
   input  logic BTN,
   output logic LEVEL,
   output logic PULSE
);

   localparam int              CNT_W    = $clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic                   btn_corr;
   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   sync2;

   debounce_state_t        state_reg, state_next;
   logic [CNT_W-1:0]       cnt_reg, cnt_next;
   logic                   level_reg, level_next;
   logic                   pulse_reg, pulse_next;

   assign btn_corr = BTN ^ ACTIVE_LOW;
   assign sync2    = sync_reg[SYNC_STAGES-1];

   // Bit 0 is sync1, the top bit is sync2; only sync2 reaches the FSM.
   always_ff @(posedge CLK) begin
      if (CLR) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn_corr};
      end
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         state_reg <= IDLE_LOW;
         cnt_reg   <= '0;
         level_reg <= 1'b0;
         pulse_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         level_reg <= level_next;
         pulse_reg <= pulse_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      level_next = level_reg;
      pulse_next = 1'b0;
      case (state_reg)
         IDLE_LOW: begin
            if (sync2) begin
               state_next = WAIT_HIGH;
               cnt_next   = CNT_ONE;
            end else begin
               cnt_next   = '0;
            end
         end
         WAIT_HIGH: begin
            if (!sync2) begin
               state_next = IDLE_LOW;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = IDLE_HIGH;
               cnt_next   = '0;
               level_next = 1'b1;
               pulse_next = EN;
            end else begin
               cnt_next   = cnt_reg + CNT_ONE;
            end
         end
         IDLE_HIGH: begin
            if (!sync2) begin
               state_next = WAIT_LOW;
               cnt_next   = CNT_ONE;
            end else begin
               cnt_next   = '0;
            end
         end
         WAIT_LOW: begin
            // Falling acceptance only updates the level; it never pulses.
            if (sync2) begin
               state_next = IDLE_HIGH;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = IDLE_LOW;
               cnt_next   = '0;
               level_next = 1'b0;
            end else begin
               cnt_next   = cnt_reg + CNT_ONE;
            end
         end
         default: begin
            state_next = IDLE_LOW;
            cnt_next   = '0;
         end
      endcase
   end

   assign LEVEL = level_reg;
   assign PULSE = pulse_reg;

endmodule : debounce_channel

// File: rtl/count_pulse_shaper.sv
// Two independent debounce channels producing clean CKA/CKB count pulses
// for the downstream ripple counter.
module count_pulse_shaper
   import count_pulse_shaper_pkg::*;
#(
   parameter int STABLE_CYCLES = 500000,
   parameter bit ACTIVE_LOW    = 1'b1
) (
   input  logic CLK,
   input  logic CLR,
   input  logic EN,
   input  logic BTN_A,
   input  logic BTN_B,
   output logic LEVEL_A,
   output logic LEVEL_B,
   output logic PULSE_A,
   output logic PULSE_B
);

   debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .ACTIVE_LOW    (ACTIVE_LOW)
   ) u_chan_a (
      .CLK   (CLK),
      .CLR   (CLR),
      .EN    (EN),
      .BTN   (BTN_A),
      .LEVEL (LEVEL_A),
      .PULSE (PULSE_A)
   );

   debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .ACTIVE_LOW    (ACTIVE_LOW)
   ) u_chan_b (
      .CLK   (CLK),
      .CLR   (CLR),
      .EN    (EN),
      .BTN   (BTN_B),
      .LEVEL (LEVEL_B),
      .PULSE (PULSE_B)
   );

endmodule : count_pulse_shaper

// File: tb/tb_count_pulse_shaper.sv
// Directed bench for count_pulse_shaper: a sample-window model checked every
// cycle, plus hand-computed edge-exact expectations for each scenario.
module tb_count_pulse_shaper;

   localparam int S = 4;

   logic clk = 1'b0;
   logic clr, en, btn_a, btn_b;
   logic level_a, level_b, pulse_a, pulse_b;

   int checks = 0;
   int errors = 0;
   bit cmp_on = 1'b0;

   count_pulse_shaper #(
      .STABLE_CYCLES (S),
      .ACTIVE_LOW    (1'b0)
   ) dut (
      .CLK     (clk),
      .CLR     (clr),
      .EN      (en),
      .BTN_A   (btn_a),
      .BTN_B   (btn_b),
      .LEVEL_A (level_a),
      .LEVEL_B (level_b),
      .PULSE_A (pulse_a),
      .PULSE_B (pulse_b)
   );

   always #5 clk = ~clk;

   // Model: input reaches the debouncer two edges late; the level flips once the
   // last S samples since the previous flip (or reset) all disagree with it.
   bit         m_s1 [2];
   bit         m_s2 [2];
   bit [S-1:0] m_win [2];
   int         m_len [2];
   bit         m_level [2];
   bit         m_pulse [2];

   always @(posedge clk) begin
      bit raw [2];
      raw[0] = btn_a;
      raw[1] = btn_b;
      for (int c = 0; c < 2; c++) begin
         if (clr) begin
            m_s1[c] = 0; m_s2[c] = 0; m_win[c] = '0; m_len[c] = 0;
            m_level[c] = 0; m_pulse[c] = 0;
         end else begin
            m_pulse[c] = 0;
            m_win[c]   = {m_win[c][S-2:0], m_s2[c]};
            m_len[c]   = m_len[c] + 1;
            if (m_len[c] >= S && m_win[c] == {S{~m_level[c]}}) begin
               m_level[c] = ~m_level[c];
               m_pulse[c] = m_level[c] & en;
               m_len[c]   = 0;
            end
            m_s2[c] = m_s1[c];
            m_s1[c] = raw[c];
         end
      end
   end

   task automatic cmp(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0b expected=%0b at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_on) begin
         cmp("model_level_a", level_a, m_level[0]);
         cmp("model_level_b", level_b, m_level[1]);
         cmp("model_pulse_a", pulse_a, m_pulse[0]);
         cmp("model_pulse_b", pulse_b, m_pulse[1]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      clr = 1; en = 1; btn_a = 1; btn_b = 1;

      // Reset with both inputs held high.
      for (int n = 1; n <= 2; n++) begin
         tick();
         cmp_on = 1;
         cmp("rst_level_a", level_a, 1'b0);
         cmp("rst_level_b", level_b, 1'b0);
         cmp("rst_pulse_a", pulse_a, 1'b0);
         cmp("rst_pulse_b", pulse_b, 1'b0);
      end
      $display("txn reset: CLR held 2 cycles, BTN_A=BTN_B=1");
      clr = 0;
      for (int n = 1; n <= 8; n++) begin
         tick();
         cmp("rel_level_a", level_a, n >= 6);
         cmp("rel_pulse_a", pulse_a, n == 6);
         cmp("rel_pulse_b", pulse_b, n == 6);
      end
      $display("txn requalify after reset release");

      // Release: level falls 6 edges later with no pulse.
      btn_a = 0; btn_b = 0;
      for (int n = 1; n <= 8; n++) begin
         tick();
         cmp("fall_level_a", level_a, n < 6);
         cmp("fall_pulse_a", pulse_a, 1'b0);
      end
      $display("txn release both channels");

      // Clean press on A only.
      btn_a = 1;
      for (int n = 1; n <= 8; n++) begin
         tick();
         cmp("press_level_a", level_a, n >= 6);
         cmp("press_pulse_a", pulse_a, n == 6);
         cmp("press_level_b", level_b, 1'b0);
         cmp("press_pulse_b", pulse_b, 1'b0);
      end
      $display("txn clean press channel A");
      btn_a = 0;
      repeat (10) tick();

      // Bounce 1,0,1,0 then hold 1.
      for (int i = 0; i < 4; i++) begin
         btn_a = (i % 2 == 0);
         tick();
         cmp("bounce_pulse_a", pulse_a, 1'b0);
      end
      btn_a = 1;
      for (int n = 1; n <= 8; n++) begin
         tick();
         cmp("bounce_final_pulse_a", pulse_a, n == 6);
      end
      $display("txn bounce rejection channel A");
      btn_a = 0;
      repeat (10) tick();

      // EN gating: levels follow, pulses suppressed.
      en = 0; btn_a = 1; btn_b = 1;
      for (int n = 1; n <= 10; n++) begin
         tick();
         cmp("gate_level_a", level_a, n >= 6);
         cmp("gate_level_b", level_b, n >= 6);
         cmp("gate_pulse_a", pulse_a, 1'b0);
         cmp("gate_pulse_b", pulse_b, 1'b0);
      end
      $display("txn press both with EN=0");
      btn_a = 0; btn_b = 0;
      repeat (10) tick();
      en = 1; btn_a = 1; btn_b = 1;
      for (int n = 1; n <= 8; n++) begin
         tick();
         cmp("en_pulse_a", pulse_a, n == 6);
         cmp("en_pulse_b", pulse_b, n == 6);
      end
      $display("txn press both with EN=1");
      btn_a = 0; btn_b = 0;
      repeat (10) tick();

      // Simultaneous press, reset at cnt=2, buttons held through release.
      btn_a = 1; btn_b = 1;
      repeat (4) tick();
      clr = 1;
      tick();
      cmp("midrst_level_a", level_a, 1'b0);
      cmp("midrst_level_b", level_b, 1'b0);
      clr = 0;
      for (int n = 1; n <= 8; n++) begin
         tick();
         cmp("midrst_pulse_a", pulse_a, n == 6);
         cmp("midrst_pulse_b", pulse_b, n == 6);
         cmp("midrst_level_b", level_b, n >= 6);
      end
      $display("txn simultaneous press with mid-count reset");

      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_count_pulse_shaper
